demux_1x4: RTL and testbench
============================

DEMUX_1X4 -- requirements
Module: demux_1x4

Interface
REQ-001: The module SHALL have parameter DATA_WIDTH, default 8, setting the width of the data path.
REQ-002: CLK  input  1  single clock for the whole block; all state SHALL update on the rising edge.
REQ-003: RST  input  1  reset, synchronous and active-high.
REQ-004: IN_DATA  input  DATA_WIDTH  word to be routed.
REQ-005: IN_VALID  input  1  IN_DATA and the selects are valid this cycle.
REQ-006: Sel1, Sel2, Sel3, Sel4  input  1 each  one-hot destination select; {Sel1,Sel2,Sel3,Sel4} = 1000/0100/0010/0001 selects OUT1/OUT2/OUT3/OUT4.
REQ-007: IN_READY  output  1  the block accepts the word this cycle.
REQ-008: OUT1..OUT4  output  DATA_WIDTH each  per-destination held data.
REQ-009: OUT_VALID1..OUT_VALID4  output  1 each  the destination slot holds an unconsumed word.
REQ-010: OUT_READY1..OUT_READY4  input  1 each  the destination consumes the word this cycle.
REQ-011: SEL_ERR  output  1  one-cycle pulse flagging that an illegal select was dropped.
REQ-012: ERR_CNT  output  8  saturating count of dropped words.

Function
REQ-013: A transfer SHALL occur when IN_VALID and IN_READY are both high on a rising CLK edge.
REQ-014: IN_READY SHALL be combinational: for a legal select, high iff the selected slot is EMPTY, or it is FULL with its OUT_READY high; for an illegal select (not exactly one bit set), high.
REQ-015: Each slot SHALL have two states: EMPTY (OUT_VALIDn=0) and FULL (OUT_VALIDn=1).
REQ-016: EMPTY->FULL on a transfer to that slot; FULL->EMPTY on OUT_READYn with no transfer to the slot; FULL stays FULL and loads the new word on simultaneous OUT_READYn and a transfer to the slot.
REQ-017: Latency SHALL be one cycle: the accepted word appears on OUTn with OUT_VALIDn high in the cycle after the transfer.
REQ-018: OUTn SHALL hold its last loaded value while EMPTY and SHALL change only on a load.
REQ-019: Non-selected slots SHALL be unaffected by a transfer.
REQ-020: OUT_READYn asserted while the slot is EMPTY SHALL have no effect.
REQ-021: A transfer with an illegal select, including 0000, SHALL load no slot, SHALL pulse SEL_ERR high for exactly the following cycle, and SHALL increment ERR_CNT.
REQ-022: ERR_CNT SHALL saturate at 255 and never wrap.
REQ-023: With IN_VALID low, SEL_ERR SHALL be low in the next cycle and ERR_CNT SHALL hold.
REQ-024: All four slots SHALL drain independently in the same cycle.

Reset
REQ-025: While RST is high on a CLK edge, all slots SHALL go EMPTY and OUT1..OUT4, SEL_ERR and ERR_CNT SHALL be 0.
REQ-026: Reset mid-operation SHALL discard held words; a transfer in the reset cycle SHALL be lost.

Structure
REQ-027: The select codes (1000/0100/0010/0001) and the slot state encoding SHALL be defined in the shared system package and used by this block and the ALU output multiplexer.
REQ-028: One slot SHALL be a sub-module demux_slot (state, data register, load/drain logic), instantiated four times.

Verification
REQ-029: Reset, then IN_DATA=0xA5 with Sel=0100 and IN_VALID for 1 cycle -> next cycle OUT2=0xA5, OUT_VALID2=1, other OUT_VALIDs 0.
REQ-030: Slot 1 FULL with OUT_READY1=0, new word 0x3C with Sel=1000 -> IN_READY=0, OUT1 unchanged; raise OUT_READY1 -> same cycle IN_READY=1, next cycle OUT1=0x3C, OUT_VALID1=1.
REQ-031: Sel=1100 with IN_VALID -> IN_READY=1, no OUT_VALID change, SEL_ERR=1 for one cycle, ERR_CNT 0->1.
REQ-032: 300 consecutive Sel=0000 transfers -> ERR_CNT=255 and held there.
REQ-033: Fill all four slots with 0x11/0x22/0x33/0x44, assert all OUT_READYs for 1 cycle -> all OUT_VALIDs 0 next cycle, OUT data held.
REQ-034: RST high with slots FULL and ERR_CNT=7 -> next cycle all OUT_VALIDs 0, OUT1..OUT4=0, ERR_CNT=0.

Source files
------------

// File: rtl/demux_1x4_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer: select codes, slot state
// encoding and small helpers used by the top level and the slot sub-module.
package demux_1x4_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int ERR_CNT_W = 8;

    // Select codes as seen on {Sel1,Sel2,Sel3,Sel4}
    localparam logic [3:0] SEL_OUT1 = 4'b1000;
    localparam logic [3:0] SEL_OUT2 = 4'b0100;
    localparam logic [3:0] SEL_OUT3 = 4'b0010;
    localparam logic [3:0] SEL_OUT4 = 4'b0001;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Select code that routes to slot idx (0 -> OUT1 ... 3 -> OUT4)
    function automatic logic [3:0] slot_sel_code(input int unsigned idx);
        logic [3:0] code;
        case (idx)
            0:       code = SEL_OUT1;
            1:       code = SEL_OUT2;
            2:       code = SEL_OUT3;
            3:       code = SEL_OUT4;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // A select is legal only when exactly one destination bit is set
    function automatic logic sel_is_legal(input logic [3:0] sel);
        return $onehot(sel);
    endfunction

endpackage

// File: rtl/demux_1x4_if.sv
// Bus bundle for the demultiplexer: upstream word/select handshake and the
// four per-destination valid/ready channels plus error reporting.
interface demux_1x4_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_VALID;
    logic                  Sel1;
    logic                  Sel2;
    logic                  Sel3;
    logic                  Sel4;
    logic                  IN_READY;

    logic [DATA_WIDTH-1:0] OUT1;
    logic [DATA_WIDTH-1:0] OUT2;
    logic [DATA_WIDTH-1:0] OUT3;
    logic [DATA_WIDTH-1:0] OUT4;
    logic                  OUT_VALID1;
    logic                  OUT_VALID2;
    logic                  OUT_VALID3;
    logic                  OUT_VALID4;
    logic                  OUT_READY1;
    logic                  OUT_READY2;
    logic                  OUT_READY3;
    logic                  OUT_READY4;

    logic                  SEL_ERR;
    logic [7:0]            ERR_CNT;

    // Producer/consumer side (drives words and destination readies)
    modport master (
        output IN_DATA, IN_VALID, Sel1, Sel2, Sel3, Sel4,
        output OUT_READY1, OUT_READY2, OUT_READY3, OUT_READY4,
        input  IN_READY,
        input  OUT1, OUT2, OUT3, OUT4,
        input  OUT_VALID1, OUT_VALID2, OUT_VALID3, OUT_VALID4,
        input  SEL_ERR, ERR_CNT
    );

    // Demultiplexer side
    modport slave (
        input  IN_DATA, IN_VALID, Sel1, Sel2, Sel3, Sel4,
        input  OUT_READY1, OUT_READY2, OUT_READY3, OUT_READY4,
        output IN_READY,
        output OUT1, OUT2, OUT3, OUT4,
        output OUT_VALID1, OUT_VALID2, OUT_VALID3, OUT_VALID4,
        output SEL_ERR, ERR_CNT
    );

endinterface

// File: rtl/demux_1x4_slot.sv
// One destination slot: a single-entry holding register with EMPTY/FULL
// state. Loads on a routed transfer, empties when the consumer takes it.
//
// state      | meaning
// SLOT_EMPTY | no unconsumed word; data_out keeps the last loaded value
// SLOT_FULL  | word held and presented with valid high
module demux_slot
    import demux_1x4_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  can_accept
);

    slot_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Next-state and data-load decision
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                // drain while empty is ignored
                if (load) begin
                    state_d = SLOT_FULL;
                    data_d  = data_in;
                end
            end
            SLOT_FULL: begin
                // load wins over drain: the old word leaves as the new one lands
                if (load) begin
                    data_d = data_in;
                end else if (drain) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A full slot can still take a word in the same cycle it is consumed
    always_comb begin
        valid      = (state_q == SLOT_FULL);
        can_accept = (state_q == SLOT_EMPTY) || drain;
        data_out   = data_q;
    end

endmodule

// File: rtl/demux_1x4.sv
// 1-to-4 demultiplexer: routes each accepted word to the slot picked by a
// one-hot select. Illegal selects are accepted and dropped, flagged with a
// one-cycle SEL_ERR pulse and counted in a saturating ERR_CNT.
module demux_1x4
    import demux_1x4_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    demux_1x4_if.slave       bus
);

    logic [3:0]            sel_vec;
    logic                  sel_legal;
    logic [NUM_SLOTS-1:0]  slot_hit;
    logic [NUM_SLOTS-1:0]  slot_load;
    logic [NUM_SLOTS-1:0]  slot_drain;
    logic [NUM_SLOTS-1:0]  slot_valid;
    logic [NUM_SLOTS-1:0]  slot_can_accept;
    logic [DATA_WIDTH-1:0] slot_data [NUM_SLOTS];
    logic                  in_ready;
    logic                  xfer;

    logic                  sel_err_q, sel_err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    assign sel_vec    = {bus.Sel1, bus.Sel2, bus.Sel3, bus.Sel4};
    assign slot_drain = {bus.OUT_READY4, bus.OUT_READY3, bus.OUT_READY2, bus.OUT_READY1};

    // Select decode, accept decision and per-slot load strobes
    always_comb begin
        sel_legal = sel_is_legal(sel_vec);
        slot_hit  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_hit[i] = (sel_vec == slot_sel_code(i));
        end
        // illegal selects are always taken so they can be dropped and counted
        in_ready  = sel_legal ? |(slot_hit & slot_can_accept) : 1'b1;
        xfer      = bus.IN_VALID && in_ready;
        slot_load = xfer ? slot_hit : '0;
    end

    // Error pulse and saturating drop counter
    always_comb begin
        sel_err_d = xfer && !sel_legal;
        err_cnt_d = err_cnt_q;
        if (sel_err_d && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        demux_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk        (CLK),
            .rst        (RST),
            .load       (slot_load[g]),
            .drain      (slot_drain[g]),
            .data_in    (bus.IN_DATA),
            .data_out   (slot_data[g]),
            .valid      (slot_valid[g]),
            .can_accept (slot_can_accept[g])
        );
    end

    assign bus.IN_READY   = in_ready;
    assign bus.OUT1       = slot_data[0];
    assign bus.OUT2       = slot_data[1];
    assign bus.OUT3       = slot_data[2];
    assign bus.OUT4       = slot_data[3];
    assign bus.OUT_VALID1 = slot_valid[0];
    assign bus.OUT_VALID2 = slot_valid[1];
    assign bus.OUT_VALID3 = slot_valid[2];
    assign bus.OUT_VALID4 = slot_valid[3];
    assign bus.SEL_ERR    = sel_err_q;
    assign bus.ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_demux_1x4.sv
// Bench for demux_1x4: directed vector table, saturation and reset
// sequences, then random traffic against a behavioural reference model.
// Bit layout for 4-bit vectors follows {Sel1,Sel2,Sel3,Sel4}: bit 3 = slot 1.
module tb_demux_1x4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    demux_1x4_if #(.DATA_WIDTH(8)) bus ();

    demux_1x4 #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [3:0]      valid;
        logic [3:0][7:0] data;
        logic            err;
        logic [7:0]      cnt;
    } exp_t;

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       exp_ready;
        logic [3:0] exp_valid;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    exp_t sb[$];

    // reference model state
    logic [3:0]      m_valid;
    logic [3:0][7:0] m_data;
    logic            m_err;
    logic [7:0]      m_cnt;

    // last observed DUT values
    logic            act_ready;
    logic [3:0]      act_valid;
    logic [3:0][7:0] act_data;
    logic            act_err;
    logic [7:0]      act_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        act_valid = {bus.OUT_VALID1, bus.OUT_VALID2, bus.OUT_VALID3, bus.OUT_VALID4};
        act_data  = {bus.OUT1, bus.OUT2, bus.OUT3, bus.OUT4};
        act_err   = bus.SEL_ERR;
        act_cnt   = bus.ERR_CNT;
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] s,
                         input logic [7:0] d, input logic [3:0] o);
        exp_t e;
        logic legal;
        logic rdy;
        logic xfer;
        int   b;
        rst          = r;
        bus.IN_VALID = v;
        bus.IN_DATA  = d;
        {bus.Sel1, bus.Sel2, bus.Sel3, bus.Sel4} = s;
        {bus.OUT_READY1, bus.OUT_READY2, bus.OUT_READY3, bus.OUT_READY4} = o;
        @(negedge clk);
        legal = ($countones(s) == 1);
        b = 0;
        for (int k = 0; k < 4; k++) if (s[k]) b = k;
        rdy = legal ? (!m_valid[b] || o[b]) : 1'b1;
        act_ready = bus.IN_READY;
        check("in_ready", {31'd0, act_ready}, {31'd0, rdy});
        xfer = v && rdy;
        if (r) begin
            m_valid = '0;
            m_data  = '0;
            m_err   = 1'b0;
            m_cnt   = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (xfer && legal && s[k]) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = d;
                end else if (o[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            m_err = xfer && !legal;
            if (m_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        e.valid = m_valid;
        e.data  = m_data;
        e.err   = m_err;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sample();
        e = sb.pop_front();
        check("out_valid", {28'd0, act_valid}, {28'd0, e.valid});
        check("out_data", act_data, e.data);
        check("sel_err", {31'd0, act_err}, {31'd0, e.err});
        check("err_cnt", {24'd0, act_cnt}, {24'd0, e.cnt});
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] sel, input logic [7:0] d,
                                input logic [3:0] o, input logic er, input logic [3:0] ev,
                                input logic ee, input logic [7:0] ec);
        vec_t t;
        t.r = 1'b0; t.v = v; t.sel = sel; t.data = d; t.ordy = o;
        t.exp_ready = er; t.exp_valid = ev; t.exp_err = ee; t.exp_cnt = ec;
        return t;
    endfunction

    vec_t vecs[16];

    initial begin
        logic [3:0] sel_pool [8];
        logic [3:0] rs;
        logic [3:0] ro;
        sel_pool = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100, 4'b1000, 4'b0001};

        m_valid = '0; m_data = '0; m_err = 1'b0; m_cnt = '0;
        rst = 1'b1;
        bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
        {bus.Sel1, bus.Sel2, bus.Sel3, bus.Sel4} = 4'b0000;
        {bus.OUT_READY1, bus.OUT_READY2, bus.OUT_READY3, bus.OUT_READY4} = 4'b0000;

        //          v  sel      data   ordy     rdy valid    err cnt
        vecs[0]  = mk(1, 4'b0100, 8'hA5, 4'b0000, 1, 4'b0100, 0, 8'd0);
        vecs[1]  = mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b0100, 0, 8'd0);
        vecs[2]  = mk(1, 4'b1000, 8'h77, 4'b0000, 1, 4'b1100, 0, 8'd0);
        vecs[3]  = mk(1, 4'b1000, 8'h3C, 4'b0000, 0, 4'b1100, 0, 8'd0);
        vecs[4]  = mk(1, 4'b1000, 8'h3C, 4'b1000, 1, 4'b1100, 0, 8'd0);
        vecs[5]  = mk(1, 4'b1100, 8'hFF, 4'b0000, 1, 4'b1100, 1, 8'd1);
        vecs[6]  = mk(0, 4'b0000, 8'h00, 4'b0000, 1, 4'b1100, 0, 8'd1);
        vecs[7]  = mk(1, 4'b0010, 8'h33, 4'b0000, 1, 4'b1110, 0, 8'd1);
        vecs[8]  = mk(1, 4'b0001, 8'h44, 4'b0000, 1, 4'b1111, 0, 8'd1);
        vecs[9]  = mk(1, 4'b1000, 8'h11, 4'b1000, 1, 4'b1111, 0, 8'd1);
        vecs[10] = mk(1, 4'b0100, 8'h22, 4'b0100, 1, 4'b1111, 0, 8'd1);
        vecs[11] = mk(0, 4'b0000, 8'h00, 4'b1111, 1, 4'b0000, 0, 8'd1);
        vecs[12] = mk(0, 4'b0000, 8'h00, 4'b1111, 1, 4'b0000, 0, 8'd1);
        vecs[13] = mk(1, 4'b0000, 8'h05, 4'b0000, 1, 4'b0000, 1, 8'd2);
        vecs[14] = mk(1, 4'b0011, 8'h06, 4'b0000, 1, 4'b0000, 1, 8'd3);
        vecs[15] = mk(0, 4'b0011, 8'h07, 4'b0000, 1, 4'b0000, 0, 8'd3);

        @(posedge clk); #1;
        drive(1, 0, 4'b0000, 8'h00, 4'b0000);
        drive(1, 0, 4'b0000, 8'h00, 4'b0000);
        check("reset_valid", {28'd0, act_valid}, 32'd0);
        check("reset_data", act_data, 32'd0);
        check("reset_cnt", {24'd0, act_cnt}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            check($sformatf("vec%0d_ready", i), {31'd0, act_ready}, {31'd0, vecs[i].exp_ready});
            check($sformatf("vec%0d_valid", i), {28'd0, act_valid}, {28'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_err", i), {31'd0, act_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_cnt", i), {24'd0, act_cnt}, {24'd0, vecs[i].exp_cnt});
            if (i == 0) check("vec0_out2", {24'd0, bus.OUT2}, 32'hA5);
            if (i == 3) check("vec3_out1_held", {24'd0, bus.OUT1}, 32'h77);
            if (i == 4) check("vec4_out1_new", {24'd0, bus.OUT1}, 32'h3C);
        end
        check("drain_data_held", act_data, 32'h11223344);

        // saturation of the drop counter
        for (int i = 0; i < 300; i++) drive(0, 1, 4'b0000, i[7:0], 4'b0000);
        check("sat_cnt", {24'd0, act_cnt}, 32'd255);
        drive(0, 1, 4'b1111, 8'h00, 4'b0000);
        check("sat_cnt_held", {24'd0, act_cnt}, 32'd255);
        drive(0, 0, 4'b0000, 8'h00, 4'b0000);
        check("sat_err_low", {31'd0, act_err}, 32'd0);

        // reset with full slots and a nonzero count; the reset-cycle transfer is lost
        drive(1, 0, 4'b0000, 8'h00, 4'b0000);
        for (int i = 0; i < 7; i++) drive(0, 1, 4'b0110, 8'h00, 4'b0000);
        drive(0, 1, 4'b1000, 8'h11, 4'b0000);
        drive(0, 1, 4'b0100, 8'h22, 4'b0000);
        drive(0, 1, 4'b0010, 8'h33, 4'b0000);
        drive(0, 1, 4'b0001, 8'h44, 4'b0000);
        check("pre_rst_cnt", {24'd0, act_cnt}, 32'd7);
        check("pre_rst_valid", {28'd0, act_valid}, 32'hF);
        drive(1, 1, 4'b0100, 8'h99, 4'b0000);
        check("rst_valid", {28'd0, act_valid}, 32'd0);
        check("rst_data", act_data, 32'd0);
        check("rst_cnt", {24'd0, act_cnt}, 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rs = sel_pool[$urandom_range(0, 7)];
            ro = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), rs,
                  8'($urandom_range(0, 255)), ro);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
